// File: rtl/key_pkg.sv
// Shared definitions for the push-button front-end: per-key state encoding
// and helper functions for timer sizing.
package key_pkg;

    typedef enum logic [2:0] {
        KS_IDLE    = 3'd0,
        KS_DEB_DN  = 3'd1,
        KS_PRESSED = 3'd2,
        KS_HELD    = 3'd3,
        KS_DEB_UP  = 3'd4
    } key_state_t;

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit width able to hold 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_fsm.sv
// One push-button: two-flop synchroniser, debounce / long-press / repeat FSM
// and its registered one-cycle pulse outputs.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// KS_IDLE    | released, waiting for the synchronised level to go low
// KS_DEB_DN  | low seen, waiting DEBOUNCE_MS of stable low to accept press
// KS_PRESSED | press accepted, timing LONG_MS towards key_long
// KS_HELD    | long press reached, key_repeat every REPEAT_MS
// KS_DEB_UP  | high seen, waiting DEBOUNCE_MS of stable high; returns to ret
module key_fsm
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic CLK_50,
    input  logic nCR,
    input  logic ms_tick,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CW = width_for(max3(DEBOUNCE_MS, LONG_MS, REPEAT_MS) + 1);

    // Terminal counts are one below the target: the tick that would make
    // cnt equal the target is the one that triggers the transition.
    localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_MS - 1);
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_MS - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]     sync;
    logic           s;
    key_state_t     state, state_nx;
    key_state_t     ret, ret_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           level_nx, press_nx, release_nx, long_nx, repeat_nx;

    assign s = sync[1];

    always_ff @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) begin
            sync        <= 2'b11;
            state       <= KS_IDLE;
            ret         <= KS_PRESSED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync        <= {sync[0], key_raw};
            state       <= state_nx;
            ret         <= ret_nx;
            cnt         <= cnt_nx;
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_long    <= long_nx;
            key_repeat  <= repeat_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ret_nx     = ret;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;

        if (ms_tick && (cnt != CNT_MAX)) begin
            cnt_nx = cnt + 1'b1;
        end

        case (state)
            KS_IDLE: begin
                if (!s) begin
                    state_nx = KS_DEB_DN;
                end
            end
            KS_DEB_DN: begin
                if (s) begin
                    state_nx = KS_IDLE;
                end else if (ms_tick && (cnt >= DEB_TC)) begin
                    state_nx = KS_PRESSED;
                    press_nx = 1'b1;
                end
            end
            KS_PRESSED: begin
                if (s) begin
                    state_nx = KS_DEB_UP;
                    ret_nx   = KS_PRESSED;
                end else if (ms_tick && (cnt >= LONG_TC)) begin
                    state_nx = KS_HELD;
                    long_nx  = 1'b1;
                end
            end
            KS_HELD: begin
                if (s) begin
                    state_nx = KS_DEB_UP;
                    ret_nx   = KS_HELD;
                end else if (ms_tick && (cnt >= REP_TC)) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end
            end
            KS_DEB_UP: begin
                if (!s) begin
                    state_nx = ret;
                end else if (ms_tick && (cnt >= DEB_TC)) begin
                    state_nx   = KS_IDLE;
                    release_nx = 1'b1;
                end
            end
            default: begin
                state_nx = KS_IDLE;
            end
        endcase

        // Every state change restarts the timer, including DEB_UP -> ret.
        if (state_nx != state) begin
            cnt_nx = '0;
        end

        level_nx = (state_nx == KS_PRESSED) || (state_nx == KS_HELD) ||
                   (state_nx == KS_DEB_UP);
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Push-button front-end: shared millisecond prescaler feeding NKEYS
// independent debounce / long-press / auto-repeat channels.
module key_input_ctrl
    import key_pkg::*;
#(
    parameter int NKEYS       = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic             CLK_50,
    input  logic             nCR,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_long,
    output logic [NKEYS-1:0] key_repeat
);

    localparam int             DIV     = ms_div(CLK_HZ);
    localparam int             PW      = width_for(DIV);
    localparam logic [PW-1:0]  PRE_TOP = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          ms_tick;

    assign ms_tick = (presc == PRE_TOP);

    always_ff @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) begin
            presc <= '0;
        end else if (ms_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_fsm #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_key (
            .CLK_50      (CLK_50),
            .nCR         (nCR),
            .ms_tick     (ms_tick),
            .key_raw     (key_raw[k]),
            .key_level   (key_level[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_long    (key_long[k]),
            .key_repeat  (key_repeat[k])
        );
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl at 10 cycles per ms: bounce rejection,
// press/release timing, long press and repeat, release glitch, reset.
module tb_key_input_ctrl;

    logic       CLK_50 = 1'b0;
    logic       nCR;
    logic [3:0] key_raw;
    logic [3:0] key_level, key_press, key_release, key_long, key_repeat;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int p_cnt, p_first, r_cnt, r_first, l_cnt, l_first;
    int rp_cnt, rp_first, rp_last, lvl_err, other_cnt;

    key_input_ctrl #(
        .NKEYS       (4),
        .CLK_HZ      (10000),
        .DEBOUNCE_MS (2),
        .LONG_MS     (5),
        .REPEAT_MS   (2)
    ) dut (
        .CLK_50      (CLK_50),
        .nCR         (nCR),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 CLK_50 = ~CLK_50;

    // Edges since reset release; ms ticks land on edges that are multiples of 10.
    always @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 12 && (cyc % 10) != p; k++) @(negedge CLK_50);
    endtask

    // Called at a negedge (offset 0). Drives key_raw[key] per offset and logs
    // pulse offsets for that key; level is expected high in [exp_press, exp_rel).
    task automatic capture(input int key, input int ncyc, input bit bounce,
                           input int up_at, input int g_at, input int g_len,
                           input int exp_press, input int exp_rel);
        logic [3:0] m;
        logic       low;
        m = 4'b0001 << key;
        p_cnt = 0; p_first = -1; r_cnt = 0; r_first = -1; l_cnt = 0; l_first = -1;
        rp_cnt = 0; rp_first = -1; rp_last = -1; lvl_err = 0; other_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge CLK_50);
            if (key_press[key])   begin if (p_cnt == 0) p_first = i; p_cnt++; end
            if (key_release[key]) begin if (r_cnt == 0) r_first = i; r_cnt++; end
            if (key_long[key])    begin if (l_cnt == 0) l_first = i; l_cnt++; end
            if (key_repeat[key])  begin if (rp_cnt == 0) rp_first = i; rp_last = i; rp_cnt++; end
            if (key_level[key] !== ((i >= exp_press) && (i < exp_rel))) lvl_err++;
            if (((key_press | key_release | key_long | key_repeat) & ~m) != 4'b0) other_cnt++;
            if (bounce) low = (i < 60) && ((i % 9) < 6);
            else        low = (i < up_at) && !((i >= g_at) && (i < g_at + g_len));
            key_raw[key] = ~low;
        end
    endtask

    initial begin
        int         bad;
        int         first_at;
        logic [3:0] first_val;

        nCR     = 1'b0;
        key_raw = 4'hF;
        repeat (3) @(negedge CLK_50);
        check("rst_outputs", {key_level, key_press, key_release, key_long, key_repeat}, 0);
        nCR = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge CLK_50);
            if ({key_level, key_press, key_release, key_long, key_repeat} != 20'h0) bad++;
        end
        check("rst_quiet_100", bad, 0);

        wait_phase(2);
        capture(0, 100, 1'b1, 0, 1000, 0, 1000, 1000);
        check("bounce_press_cnt", p_cnt, 0);
        check("bounce_level", lvl_err, 0);

        repeat (20) @(negedge CLK_50);
        wait_phase(2);
        capture(0, 80, 1'b0, 40, 1000, 0, 18, 58);
        check("clean_press_cnt", p_cnt, 1);
        check("clean_press_at", p_first, 18);
        check("clean_release_cnt", r_cnt, 1);
        check("clean_release_at", r_first, 58);
        check("clean_no_long", l_cnt, 0);
        check("clean_level", lvl_err, 0);
        check("clean_others_quiet", other_cnt, 0);

        repeat (20) @(negedge CLK_50);
        wait_phase(2);
        capture(1, 190, 1'b0, 150, 1000, 0, 18, 168);
        check("long_press_at", p_first, 18);
        check("long_cnt", l_cnt, 1);
        check("long_at", l_first, 68);
        check("long_repeat_cnt", rp_cnt, 4);
        check("long_repeat_first", rp_first, 88);
        check("long_repeat_last", rp_last, 148);
        check("long_release_cnt", r_cnt, 1);
        check("long_release_at", r_first, 168);
        check("long_level", lvl_err, 0);

        repeat (20) @(negedge CLK_50);
        wait_phase(2);
        capture(2, 140, 1'b0, 100, 75, 8, 18, 118);
        check("glitch_long_at", l_first, 68);
        check("glitch_repeat_cnt", rp_cnt, 1);
        check("glitch_repeat_at", rp_first, 98);
        check("glitch_release_cnt", r_cnt, 1);
        check("glitch_release_at", r_first, 118);
        check("glitch_level", lvl_err, 0);

        repeat (20) @(negedge CLK_50);
        wait_phase(2);
        key_raw   = 4'h0;
        first_at  = -1;
        first_val = 4'h0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK_50);
            if (first_at < 0 && key_press != 4'h0) begin
                first_at  = i;
                first_val = key_press;
            end
        end
        check("simul_press_at", first_at, 18);
        check("simul_press_val", first_val, 4'hF);
        check("simul_level_held", key_level, 4'hF);

        nCR = 1'b0;
        #1;
        check("midhold_rst_outputs", {key_level, key_press, key_release, key_long, key_repeat}, 0);
        repeat (3) @(negedge CLK_50);
        nCR       = 1'b1;
        first_at  = -1;
        first_val = 4'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK_50);
            if (first_at < 0 && key_press != 4'h0) begin
                first_at  = i;
                first_val = key_press;
            end
        end
        check("post_rst_press_at", first_at, 20);
        check("post_rst_press_val", first_val, 4'hF);
        check("post_rst_level", key_level, 4'hF);

        key_raw = 4'hF;
        repeat (40) @(negedge CLK_50);
        check("final_level_released", key_level, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
Front-end for the clock's push-buttons (hour/minute set, alarm control, mode). It synchronises and debounces raw active-low key inputs, then turns each into one-cycle press, release, long-press and auto-repeat pulses on CLK_50. The clock/alarm/mode logic consumes these pulses instead of raw levels, on the input side opposite the display driver.

Parameters:
NKEYS, 4, number of independent keys
CLK_HZ, 50000000, CLK_50 frequency; must be a multiple of 1000
DEBOUNCE_MS, 20, stable time required to accept a press or a release (>=1)
LONG_MS, 1000, hold time after press acceptance before key_long fires (>=1)
REPEAT_MS, 200, auto-repeat period while held past LONG_MS (>=1)

Ports:
CLK_50  in  1  system clock
nCR  in  1  asynchronous active-low reset
key_raw  in  NKEYS  raw button levels, 0 = pressed, asynchronous to CLK_50
key_level  out  NKEYS  debounced state, 1 = pressed
key_press  out  NKEYS  one-cycle pulse when a press is accepted
key_release  out  NKEYS  one-cycle pulse when a release is accepted
key_long  out  NKEYS  one-cycle pulse when hold reaches LONG_MS
key_repeat  out  NKEYS  one-cycle pulse every REPEAT_MS after key_long

Behaviour:
- Reset: synchroniser flops = 1 (released), prescaler = 0, every FSM in IDLE, ms counters = 0, all outputs 0. Reset is honoured mid-press.
- Synchroniser: 2 flops per key. s = synchronised key_raw. Latency from raw edge is 2 cycles.
- Prescaler: free-running, 0..CLK_HZ/1000-1. ms_tick is high for one cycle when it wraps. The prescaler is shared by all keys.
- Per-key FSM. cnt counts ms_ticks, saturates, and clears on every state change.
  IDLE: level 0. s=0 -> DEB_DN.
  DEB_DN: s=1 -> IDLE, no output. cnt reaches DEBOUNCE_MS -> PRESSED and key_press.
  PRESSED: level 1. s=1 -> DEB_UP (ret=PRESSED). cnt reaches LONG_MS -> HELD and key_long.
  HELD: level 1. Each time cnt reaches REPEAT_MS -> key_repeat, cnt cleared. s=1 -> DEB_UP (ret=HELD).
  DEB_UP: level stays 1. s=0 -> state ret, cnt cleared. cnt reaches DEBOUNCE_MS -> IDLE, key_release, level 0.
- Because ms_tick phase is arbitrary, accepted times fall between N-1 and N ms after entry.
- All outputs are registered. A pulse is high in the same cycle the FSM holds its new state, for exactly one cycle.
- Pulse ordering within one press:
  - key_press precedes key_long, which precedes the first key_repeat.
  - key_long and key_repeat never occur in the same cycle.
  - The first key_repeat comes REPEAT_MS after key_long.
- Keys are fully independent. Any combination of pulses on different bits may occur in the same cycle.
- A re-press after IDLE always starts a fresh debounce. A key still held low when nCR deasserts is debounced as a new press.
- cnt width is clog2(max(DEBOUNCE_MS, LONG_MS, REPEAT_MS)+1). Prescaler width is clog2(CLK_HZ/1000).

Decomposition:
- Shared package key_pkg holds:
  - state encoding constants KS_IDLE, KS_DEB_DN, KS_PRESSED, KS_HELD, KS_DEB_UP;
  - a ms_div function CLK_HZ/1000.
- Sub-module key_fsm covers one key: synchroniser, FSM, cnt and its four pulse outputs.
- key_input_ctrl holds the shared prescaler and a generate loop of NKEYS key_fsm instances.

Test Plan:
Bench parameters: CLK_HZ=10000 (10 cycles per ms), DEBOUNCE_MS=2, LONG_MS=5, REPEAT_MS=2, NKEYS=4.
- Reset: key_raw=4'hF, nCR low then high -> all outputs 0 for 100 cycles.
- Bounce rejection: key_raw[0] toggles low 6 cycles / high 3 cycles for 60 cycles, then stays high -> key_press[0] never asserted, key_level[0]=0 throughout.
- Clean press: key_raw[0] low for 40 cycles, then high -> key_press[0] exactly once, 12-22 cycles after the falling edge. key_level[0]=1 until key_release[0] fires exactly once, 12-22 cycles after the rising edge. No key_long.
- Long hold: key_raw[1] low for 150 cycles -> key_press, then key_long about 50 cycles later, then key_repeat every 20 cycles (4 pulses before release), then one key_release.
- Release glitch: during a hold of key_raw[2], high for 8 cycles -> no key_release, key_level[2] stays 1, FSM returns to the held state.
- Simultaneous keys and reset: key_raw=4'h0 -> all four key_press bits in the same cycle. Mid-hold nCR=0 -> all outputs 0 immediately. After nCR=1 with keys still low, four fresh key_press pulses follow after debounce.
